// File: rtl/pcie_tlp_pkg.sv
// Shared TLP constants and completion-path types.
// Used by both the completion transmitter and the receive decoder.
package pcie_tlp_pkg;

    localparam logic [7:0] TLP_CPLD  = 8'h4A;
    localparam logic [7:0] TLP_CPL   = 8'h0A;
    localparam logic [7:0] TLP_MRD32 = 8'h00;
    localparam logic [7:0] TLP_MWR32 = 8'h40;

    localparam logic [2:0] CPL_SC  = 3'b000;
    localparam logic [2:0] CPL_UR  = 3'b001;
    localparam logic [2:0] CPL_CRS = 3'b010;
    localparam logic [2:0] CPL_CA  = 3'b100;

    localparam logic [11:0] CPL_BYTES_1DW = 12'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND
    } cpl_state_t;

endpackage

// File: rtl/pcie_cpl_tx.sv
// Single-DW CplD transmitter onto the 16-bit VC0 tx port.
// Credits are checked at accept; the TLP is sent without stalls.
module pcie_cpl_tx
    import pcie_tlp_pkg::*;
#(
    parameter logic [2:0] CPL_STATUS = CPL_SC
) (
    input  logic        pcie_clk,
    input  logic        sys_rst,
    input  logic [7:0]  bus_num,
    input  logic [4:0]  dev_num,
    input  logic [2:0]  func_num,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_rid,
    input  logic [7:0]  req_tag,
    input  logic [6:0]  req_laddr,
    input  logic [31:0] req_data,
    output logic        tx_req,
    input  logic        tx_rdy,
    output logic        tx_st,
    output logic        tx_end,
    output logic [15:0] tx_data,
    input  logic [8:0]  tx_ca_cplh,
    input  logic [12:0] tx_ca_cpld,
    output logic [15:0] cpl_count
);

    cpl_state_t  state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic        req_nxt, st_nxt, end_nxt;
    logic [15:0] data_nxt;
    logic        credit_ok, accept;

    logic [15:0] lat_cid;
    logic [15:0] lat_rid;
    logic [7:0]  lat_tag;
    logic [6:0]  lat_laddr;
    logic [31:0] lat_data;

    assign credit_ok = (tx_ca_cplh[8] | (tx_ca_cplh[7:0] != 8'd0))
                     & (tx_ca_cpld[12] | (tx_ca_cpld[11:0] != 12'd0));
    assign req_ready = (state == ST_IDLE) & credit_ok & ~sys_rst;
    assign accept    = req_valid & req_ready;

    // Payload bytes go out little-endian within each halfword.
    function automatic logic [15:0] tlp_word(
        input logic [2:0]  i,
        input logic [15:0] cid,
        input logic [15:0] rid,
        input logic [7:0]  tag,
        input logic [6:0]  laddr,
        input logic [31:0] d
    );
        logic [15:0] w;
        w = 16'h0000;
        unique case (i)
            3'd0: w = {TLP_CPLD, 8'h00};
            3'd1: w = 16'h0001;
            3'd2: w = cid;
            3'd3: w = {CPL_STATUS, 1'b0, CPL_BYTES_1DW};
            3'd4: w = rid;
            3'd5: w = {tag, 1'b0, laddr};
            3'd6: w = {d[7:0], d[15:8]};
            3'd7: w = {d[23:16], d[31:24]};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Latch the request and completer ID at accept.
    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            lat_cid   <= '0;
            lat_rid   <= '0;
            lat_tag   <= '0;
            lat_laddr <= '0;
            lat_data  <= '0;
        end else if (accept) begin
            lat_cid   <= {bus_num, dev_num, func_num};
            lat_rid   <= req_rid;
            lat_tag   <= req_tag;
            lat_laddr <= req_laddr;
            lat_data  <= req_data;
        end
    end

    // Next state and next registered tx outputs.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        req_nxt   = 1'b0;
        st_nxt    = 1'b0;
        end_nxt   = 1'b0;
        data_nxt  = 16'h0000;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_REQ;
                    req_nxt   = 1'b1;
                end
            end
            ST_REQ: begin
                if (tx_rdy) begin
                    state_nxt = ST_SEND;
                    idx_nxt   = 3'd0;
                    st_nxt    = 1'b1;
                end else begin
                    req_nxt = 1'b1;
                end
            end
            ST_SEND: begin
                if (idx == 3'd7) begin
                    state_nxt = ST_IDLE;
                end else begin
                    idx_nxt = idx + 3'd1;
                    end_nxt = (idx == 3'd6);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_SEND)
            data_nxt = tlp_word(idx_nxt, lat_cid, lat_rid,
                                lat_tag, lat_laddr, lat_data);
    end

    // State, word index, registered tx outputs and completion counter.
    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            tx_req    <= 1'b0;
            tx_st     <= 1'b0;
            tx_end    <= 1'b0;
            tx_data   <= 16'h0000;
            cpl_count <= 16'h0000;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            tx_req  <= req_nxt;
            tx_st   <= st_nxt;
            tx_end  <= end_nxt;
            tx_data <= data_nxt;
            if (end_nxt)
                cpl_count <= cpl_count + 16'd1;
        end
    end

endmodule
